// File: rtl/ff_readback_serializer_if.sv
// Handshake/bus bundle for ff_readback_serializer.
//   snap_req    : one-cycle request to capture ff_state and start a frame
//   ff_state    : parallel flip-flop outputs to read back
//   sout        : serial data bit, 0 whenever sout_valid is low
//   sout_valid  : sout holds a valid bit
//   sout_ready  : consumer accepts the bit (transfer = sout_valid & sout_ready)
//   sout_last   : final bit of the frame
//   busy        : frame in progress
//   done        : one-cycle pulse after the final bit transfers
//   overrun     : sticky, snap_req arrived while busy
//   clr_overrun : synchronous clear of overrun
// master: requester/consumer side. slave: the serializer.
interface ff_readback_serializer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             snap_req;
    logic [WIDTH-1:0] ff_state;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_last;
    logic             busy;
    logic             done;
    logic             overrun;
    logic             clr_overrun;

    modport master (
        output snap_req, ff_state, sout_ready, clr_overrun,
        input  sout, sout_valid, sout_last, busy, done, overrun
    );

    modport slave (
        input  snap_req, ff_state, sout_ready, clr_overrun,
        output sout, sout_valid, sout_last, busy, done, overrun
    );
endinterface

// File: rtl/ff_readback_serializer.sv
// Flip-flop readback serializer.
// Captures a snapshot of a parallel flip-flop vector on snap_req and shifts it out
// MSB-first over a 1-bit valid/ready stream, optionally followed by an even-parity bit.
// Ports:
//   clk : clock, all state changes on posedge
//   rst : asynchronous active-high reset, aborts any frame in flight
//   bus : ff_readback_serializer_if.slave (request, snapshot input, serial stream,
//         status flags busy/done/overrun, clr_overrun)
// All outputs are registered, so asynchronous reset forces them low immediately.
module ff_readback_serializer #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          PARITY_EN = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    ff_readback_serializer_if.slave  bus
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] snapshot_q;
    logic [CntW-1:0]  cnt_q;
    logic             parity_q;
    logic             sout_q;
    logic             sout_valid_q;
    logic             sout_last_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.sout_last  = sout_last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            snapshot_q   <= '0;
            cnt_q        <= '0;
            parity_q     <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A request that cannot be accepted sets overrun; set beats clear.
            if (bus.snap_req && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.snap_req) begin
                        snapshot_q   <= bus.ff_state;
                        parity_q     <= ^bus.ff_state;
                        cnt_q        <= CntW'(WIDTH - 1);
                        state_q      <= StShift;
                        sout_q       <= bus.ff_state[WIDTH-1];
                        sout_valid_q <= 1'b1;
                        sout_last_q  <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end

                StShift: begin
                    if (bus.sout_ready) begin
                        snapshot_q <= snapshot_q << 1;
                        if (cnt_q == '0) begin
                            if (PARITY_EN) begin
                                state_q     <= StParity;
                                sout_q      <= parity_q;
                                sout_last_q <= 1'b1;
                            end else begin
                                state_q      <= StDone;
                                sout_q       <= 1'b0;
                                sout_valid_q <= 1'b0;
                                sout_last_q  <= 1'b0;
                                done_q       <= 1'b1;
                            end
                        end else begin
                            cnt_q       <= cnt_q - 1'b1;
                            // Next bit to present is the one just below the current MSB.
                            sout_q      <= snapshot_q[WIDTH-2];
                            sout_last_q <= (cnt_q == CntW'(1)) && !PARITY_EN;
                        end
                    end
                end

                StParity: begin
                    if (bus.sout_ready) begin
                        state_q      <= StDone;
                        sout_q       <= 1'b0;
                        sout_valid_q <= 1'b0;
                        sout_last_q  <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q      <= StIdle;
                    sout_q       <= 1'b0;
                    sout_valid_q <= 1'b0;
                    sout_last_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ff_readback_serializer.md
Name: ff_readback_serializer

Overview:
- Readback side of the flip-flop storage examples: captures a snapshot of a parallel vector of flip-flop outputs on request, then shifts it out serially MSB-first.
- Serial output uses a valid/ready handshake and an optional even-parity trailer bit.
- Used to observe register contents from the FPGA architecture examples through a 1-bit debug/scan path.

Parameters:
- WIDTH, 16, number of flip-flop state bits captured per frame (>= 2).
- PARITY_EN, 1, 1 appends one even-parity bit after the data bits; 0 sends no trailer.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- snap_req  input  1  one-cycle request to capture ff_state and start a frame.
- ff_state  input  WIDTH  parallel flip-flop outputs to read back.
- sout  output  1  serial data bit; 0 whenever sout_valid=0.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  consumer accepts the bit; transfer = sout_valid & sout_ready.
- sout_last  output  1  marks the final bit of the frame: the parity bit, or data bit 0 when PARITY_EN=0.
- busy  output  1  frame in progress; high in every state except IDLE.
- done  output  1  one-cycle pulse after the final bit transfers.
- overrun  output  1  sticky: snap_req arrived while busy.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset, asynchronous, active-high:
  - State goes to IDLE; snapshot, bit counter and parity register clear to 0.
  - sout, sout_valid, sout_last, busy, done and overrun all read 0 immediately, without waiting for a clock edge.
  - Asserting rst mid-frame aborts the frame: no done pulse, remaining bits are discarded.
- States: IDLE, SHIFT, PARITY (exists only when PARITY_EN=1), DONE.
- IDLE: when snap_req=1 at a clock edge:
  - snapshot <= ff_state.
  - parity <= XOR of all ff_state bits.
  - counter <= WIDTH-1.
  - Next state is SHIFT.
  - Latency: snap_req sampled at edge N gives sout_valid=1 in the cycle after edge N.
- SHIFT:
  - sout_valid=1 and sout=snapshot[WIDTH-1].
  - On a transfer the snapshot shifts left by 1 and the counter decrements.
  - On a transfer with counter==0, go to PARITY if PARITY_EN=1, else to DONE.
  - sout_last=1 only when counter==0 and PARITY_EN=0.
- PARITY: sout_valid=1, sout=parity, sout_last=1. Go to DONE on transfer.
- DONE: sout_valid=0, done=1, busy=1 for exactly one cycle, then IDLE.
- Backpressure: while sout_valid=1 and sout_ready=0, sout, sout_last and all internal state hold stable. sout_ready has no effect when sout_valid=0.
- Frame length: WIDTH+PARITY_EN transfers.
  - With sout_ready held high, done is high in the cycle after the last transfer.
  - busy falls one cycle after that.
  - Back-to-back frames: a snap_req is accepted in the first IDLE cycle.
- Overrun:
  - snap_req in SHIFT, PARITY or DONE is ignored and sets overrun.
  - clr_overrun=1 clears overrun at the next edge.
  - If a set and a clear occur in the same cycle, set wins.
- ff_state is sampled only at the accepting edge. Later changes never affect the frame in flight.

Test Plan:
- WIDTH=8, PARITY_EN=1, ff_state=8'hA5, snap_req pulse at edge 0, sout_ready=1:
  - sout_valid is high for 9 cycles, with sout sequence 1,0,1,0,0,1,0,1 then parity 0.
  - sout_last=1 only on the 9th bit; done pulses on the next cycle; busy is high for 10 cycles.
- Same setup with ff_state=8'h07 and sout_ready toggling 1,0,0,1,...:
  - Bits are 0,0,0,0,0,1,1,1 with parity 1.
  - sout and sout_last stay stable through every stall cycle; no bit is lost or duplicated.
- PARITY_EN=0, ff_state=8'h81:
  - Exactly 8 transfers: 1,0,0,0,0,0,0,1.
  - sout_last=1 on the 8th bit; done follows one cycle later.
- snap_req pulse during SHIFT (ff_state changed to 8'hFF mid-frame):
  - The frame continues with the original 8'hA5 bits; overrun goes to 1 and stays 1.
  - clr_overrun clears it; clr_overrun together with a new overrun in the same cycle leaves overrun=1.
- rst asserted after the 3rd transfer:
  - sout_valid, busy and overrun drop to 0 asynchronously; no done pulse.
  - After rst deasserts, a new snap_req with 8'h3C produces a full, correct frame.
